// File: rtl/mac_mode_scheduler.sv
// Round-robin scheduler for one shared 27x27 / SIMD multiplier: owns the mode register,
// drains the pipeline before a mode change, and returns tagged results in issue order.
module mac_mode_scheduler #(
  parameter int LATENCY    = 2,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_mode,
  input  logic [80:0]     req0_a,
  input  logic [80:0]     req0_b,
  input  logic            req0_a_sign,
  input  logic            req0_b_sign,
  input  logic [ID_W-1:0] req0_id,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_mode,
  input  logic [80:0]     req1_a,
  input  logic [80:0]     req1_b,
  input  logic            req1_a_sign,
  input  logic            req1_b_sign,
  input  logic [ID_W-1:0] req1_id,
  output logic [80:0]     mult_a,
  output logic [80:0]     mult_b,
  output logic            mult_a_sign,
  output logic            mult_b_sign,
  output logic [1:0]      mult_mode,
  input  logic [53:0]     mult_result_0,
  input  logic [53:0]     mult_result_1,
  input  logic [11:0]     mult_simd_carry,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [53:0]     rsp_result_0,
  output logic [53:0]     rsp_result_1,
  output logic [11:0]     rsp_simd_carry,
  output logic            rsp_src,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_err,
  output logic            busy
);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam int EW  = 54 + 54 + 12 + 1 + ID_W + 1;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_SWITCH = 2'd2} state_t;

  state_t             r_state, w_state_next;
  logic [1:0]         r_mode;
  logic               r_ptr;
  logic [CW-1:0]      r_inflight, r_count;
  logic [PW-1:0]      r_wptr, r_rptr;
  logic [LATENCY-1:0] r_pipe_vld, r_pipe_src, r_pipe_err;
  logic [ID_W-1:0]    r_pipe_id [LATENCY];
  logic [EW-1:0]      r_mem [FIFO_DEPTH];

  logic               w_gnt_vld, w_gnt, w_illegal, w_credit, w_accept, w_capture, w_pop;
  logic               w_in_run, w_load_mode;
  logic [1:0]         w_gnt_mode;
  logic [80:0]        w_gnt_a, w_gnt_b;
  logic               w_gnt_a_sign, w_gnt_b_sign;
  logic [ID_W-1:0]    w_gnt_id;
  logic [EW-1:0]      w_wdata, w_head;

  assign w_gnt_vld    = req0_valid | req1_valid;
  assign w_gnt        = (req0_valid & req1_valid) ? r_ptr : req1_valid;
  assign w_gnt_mode   = w_gnt ? req1_mode   : req0_mode;
  assign w_gnt_a      = w_gnt ? req1_a      : req0_a;
  assign w_gnt_b      = w_gnt ? req1_b      : req0_b;
  assign w_gnt_a_sign = w_gnt ? req1_a_sign : req0_a_sign;
  assign w_gnt_b_sign = w_gnt ? req1_b_sign : req0_b_sign;
  assign w_gnt_id     = w_gnt ? req1_id     : req0_id;
  assign w_illegal    = (w_gnt_mode == 2'b11);

  // Credit uses registered occupancy, so a pop only frees a slot on the following cycle.
  assign w_credit  = ({1'b0, r_inflight} + {1'b0, r_count}) < CW1'(FIFO_DEPTH);
  assign w_accept  = reset & w_gnt_vld & w_in_run & w_credit & (w_illegal | (w_gnt_mode == r_mode));
  assign w_capture = r_pipe_vld[LATENCY-1];
  assign w_pop     = rsp_valid & rsp_ready;

  assign req0_ready = w_accept & ~w_gnt;
  assign req1_ready = w_accept & w_gnt;
  assign mult_mode  = r_mode;
  assign busy       = (r_inflight != '0) | (r_count != '0) | (r_state != ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_mode  <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if (w_load_mode) r_mode <= w_gnt_mode;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (w_gnt_vld && !w_illegal && (w_gnt_mode != r_mode)) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!w_gnt_vld)               w_state_next = ST_RUN;
        else if (r_inflight == '0)    w_state_next = w_illegal ? ST_RUN : ST_SWITCH;
      end
      ST_SWITCH: w_state_next = ST_RUN;
      default:   w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_in_run    = (r_state == ST_RUN);
    w_load_mode = (r_state == ST_DRAIN) & w_gnt_vld & (r_inflight == '0) & ~w_illegal;
  end

  // Issue register and tag pipeline; illegal-mode slots present zero operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_a      <= '0;
      mult_b      <= '0;
      mult_a_sign <= 1'b0;
      mult_b_sign <= 1'b0;
      r_pipe_vld  <= '0;
      r_pipe_src  <= '0;
      r_pipe_err  <= '0;
      r_ptr       <= 1'b0;
      for (int i = 0; i < LATENCY; i++) r_pipe_id[i] <= '0;
    end else begin
      if (w_accept) begin
        mult_a      <= w_illegal ? '0   : w_gnt_a;
        mult_b      <= w_illegal ? '0   : w_gnt_b;
        mult_a_sign <= w_illegal ? 1'b0 : w_gnt_a_sign;
        mult_b_sign <= w_illegal ? 1'b0 : w_gnt_b_sign;
        if (req0_valid & req1_valid) r_ptr <= ~w_gnt;
      end
      r_pipe_vld[0] <= w_accept;
      r_pipe_src[0] <= w_gnt;
      r_pipe_err[0] <= w_illegal;
      r_pipe_id[0]  <= w_gnt_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_src[i] <= r_pipe_src[i-1];
        r_pipe_err[i] <= r_pipe_err[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      case ({w_accept, w_capture})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_capture) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
    end
  end

  assign w_wdata = r_pipe_err[LATENCY-1]
                 ? {120'd0, r_pipe_src[LATENCY-1], r_pipe_id[LATENCY-1], 1'b1}
                 : {mult_result_0, mult_result_1, mult_simd_carry,
                    r_pipe_src[LATENCY-1], r_pipe_id[LATENCY-1], 1'b0};

  always_ff @(posedge clk) begin
    if (w_capture) r_mem[r_wptr] <= w_wdata;
  end

  assign w_head    = r_mem[r_rptr];
  assign rsp_valid = (r_count != '0);
  assign {rsp_result_0, rsp_result_1, rsp_simd_carry, rsp_src, rsp_id, rsp_err} =
         rsp_valid ? w_head : '0;

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(w_capture && (r_count == CW'(FIFO_DEPTH))));
  a_mode_stable: assert property (@(posedge clk) disable iff (!reset)
    (r_inflight != '0) |=> $stable(r_mode));
endmodule

// File: tb/tb_mac_mode_scheduler.sv
// Bench for mac_mode_scheduler: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model and a stand-in multiplier.
module tb_mac_mode_scheduler;
  localparam int LAT = 2;
  localparam int IDW = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic req0_valid, req0_ready, req0_a_sign, req0_b_sign;
  logic req1_valid, req1_ready, req1_a_sign, req1_b_sign;
  logic [1:0] req0_mode, req1_mode, mult_mode;
  logic [80:0] req0_a, req0_b, req1_a, req1_b, mult_a, mult_b;
  logic [IDW-1:0] req0_id, req1_id, rsp_id;
  logic mult_a_sign, mult_b_sign, rsp_valid, rsp_ready, rsp_src, rsp_err, busy;
  logic [53:0] mult_result_0, mult_result_1, rsp_result_0, rsp_result_1;
  logic [11:0] mult_simd_carry, rsp_simd_carry;

  mac_mode_scheduler #(.LATENCY(LAT), .ID_W(IDW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_a_sign(req0_a_sign), .req0_b_sign(req0_b_sign),
    .req0_id(req0_id),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_a_sign(req1_a_sign), .req1_b_sign(req1_b_sign),
    .req1_id(req1_id),
    .mult_a(mult_a), .mult_b(mult_b), .mult_a_sign(mult_a_sign), .mult_b_sign(mult_b_sign),
    .mult_mode(mult_mode), .mult_result_0(mult_result_0), .mult_result_1(mult_result_1),
    .mult_simd_carry(mult_simd_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result_0(rsp_result_0),
    .rsp_result_1(rsp_result_1), .rsp_simd_carry(rsp_simd_carry), .rsp_src(rsp_src),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct packed {logic [53:0] r0; logic [53:0] r1; logic [11:0] c;} res_t;
  typedef struct {logic src; logic [IDW-1:0] id; logic err; res_t res; int cap;} ent_t;
  typedef struct {logic src; logic [IDW-1:0] id; logic err; logic [53:0] r0;} log_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: a scheduler state, in-flight list with capture times, and a result queue.
  int         m_st;
  logic [1:0] m_mode;
  logic       m_ptr;
  ent_t       m_fl[$];
  ent_t       m_ff[$];
  logic       exp_iss, exp_sa, exp_sb;
  logic [80:0] exp_a, exp_b;
  log_t       rsp_log[$];
  logic       acc0, acc1;

  logic [80:0] pa, pb;
  logic        psa, psb;
  logic [1:0]  pmode;

  // Stand-in multiplier: real 27x27 product in mode 00, a distinct mixing function otherwise.
  function automatic res_t mulf(input logic [80:0] a, input logic [80:0] b,
                                input logic sa, input logic sb, input logic [1:0] mode);
    res_t r;
    logic signed [54:0] ax, bx;
    logic signed [109:0] p;
    r = '0;
    if (mode == 2'b00) begin
      ax = sa ? {{28{a[26]}}, a[26:0]} : {28'd0, a[26:0]};
      bx = sb ? {{28{b[26]}}, b[26:0]} : {28'd0, b[26:0]};
      p = ax * bx;
      r.r0 = p[53:0];
    end else begin
      r.r0 = a[53:0] ^ b[53:0];
      r.r1 = a[80:27] + b[80:27];
      r.c  = a[11:0] ^ {b[5:0], b[11:6]};
    end
    return r;
  endfunction

  function automatic logic [80:0] r81();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[80:0];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_st = 0; m_mode = 2'b00; m_ptr = 1'b0; exp_iss = 1'b0;
    m_fl.delete(); m_ff.delete();
  endtask

  task automatic set_req(input int n, input logic v, input logic [1:0] m, input logic [80:0] a,
                         input logic [80:0] b, input logic sa, input logic sb,
                         input logic [IDW-1:0] id);
    if (n == 0) begin
      req0_valid = v; req0_mode = m; req0_a = a; req0_b = b;
      req0_a_sign = sa; req0_b_sign = sb; req0_id = id;
    end else begin
      req1_valid = v; req1_mode = m; req1_a = a; req1_b = b;
      req1_a_sign = sa; req1_b_sign = sb; req1_id = id;
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // One clock cycle: compare the DUT against the model, advance the model, then the edge.
  task automatic tick();
    logic v0, v1, gv, g, rdy, credit, err;
    logic [1:0] gm;
    logic [80:0] ga, gb;
    logic gsa, gsb;
    logic [IDW-1:0] gid;
    ent_t e;
    res_t r;
    int nif;
    #1;
    v0 = req0_valid; v1 = req1_valid;
    gv = v0 | v1;
    g  = (v0 & v1) ? m_ptr : v1;
    gm = g ? req1_mode : req0_mode;
    ga = g ? req1_a : req0_a;  gb = g ? req1_b : req0_b;
    gsa = g ? req1_a_sign : req0_a_sign;  gsb = g ? req1_b_sign : req0_b_sign;
    gid = g ? req1_id : req0_id;
    err = (gm == 2'b11);
    credit = (m_fl.size() + m_ff.size()) < DEPTH;
    rdy = reset && gv && (m_st == 0) && credit && ((gm == m_mode) || err);

    chk("req0_ready", req0_ready, rdy && !g);
    chk("req1_ready", req1_ready, rdy && g);
    chk("mult_mode", mult_mode, m_mode);
    chk("rsp_valid", rsp_valid, m_ff.size() > 0);
    chk("busy", busy, (m_fl.size() != 0) || (m_ff.size() != 0) || (m_st != 0));
    if (m_ff.size() > 0) begin
      chk("rsp_result_0", rsp_result_0, m_ff[0].res.r0);
      chk("rsp_result_1", rsp_result_1, m_ff[0].res.r1);
      chk("rsp_carry", rsp_simd_carry, m_ff[0].res.c);
      chk("rsp_src", rsp_src, m_ff[0].src);
      chk("rsp_id", rsp_id, m_ff[0].id);
      chk("rsp_err", rsp_err, m_ff[0].err);
    end
    if (exp_iss) begin
      chk("mult_a", mult_a, exp_a);
      chk("mult_b", mult_b, exp_b);
      chk("mult_signs", {mult_a_sign, mult_b_sign}, {exp_sa, exp_sb});
    end
    if (rsp_valid && rsp_ready)
      rsp_log.push_back('{src: rsp_src, id: rsp_id, err: rsp_err, r0: rsp_result_0});
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;

    if (reset) begin
      nif = m_fl.size();
      if (m_ff.size() > 0 && rsp_ready) void'(m_ff.pop_front());
      if (nif > 0 && m_fl[0].cap == cyc) m_ff.push_back(m_fl.pop_front());
      exp_iss = rdy;
      if (rdy) begin
        e.src = g; e.id = gid; e.err = err; e.cap = cyc + LAT;
        e.res = err ? '0 : mulf(ga, gb, gsa, gsb, m_mode);
        m_fl.push_back(e);
        exp_a = err ? '0 : ga;  exp_b = err ? '0 : gb;
        exp_sa = err ? 1'b0 : gsa;  exp_sb = err ? 1'b0 : gsb;
        if (v0 && v1) m_ptr = !g;
      end
      case (m_st)
        0: if (gv && !err && gm != m_mode) m_st = 1;
        1: begin
          if (!gv) m_st = 0;
          else if (nif == 0) begin
            if (!err) begin m_mode = gm; m_st = 2; end
            else m_st = 0;
          end
        end
        default: m_st = 0;
      endcase
    end

    @(posedge clk);
    cyc++;
    #1;
    r = mulf(pa, pb, psa, psb, pmode);
    mult_result_0 = r.r0; mult_result_1 = r.r1; mult_simd_carry = r.c;
    pa = mult_a; pb = mult_b; psa = mult_a_sign; psb = mult_b_sign; pmode = mult_mode;
  endtask

  initial begin
    int nacc, w;
    logic got;
    logic [3:0] order;
    logic [1:0] phase, m;

    reset = 1'b1;
    idle();
    set_req(0, 0, 0, '0, '0, 0, 0, '0);
    set_req(1, 0, 0, '0, '0, 0, 0, '0);
    rsp_ready = 1'b1;
    mult_result_0 = '0; mult_result_1 = '0; mult_simd_carry = '0;
    pa = '0; pb = '0; psa = 0; psb = 0; pmode = 0;
    #1 reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_busy", busy, 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Single mode-00 request: 3*5 on req0.
    set_req(0, 1, 2'b00, 81'd3, 81'd5, 0, 0, 4'h7);
    tick();
    chk("t1_accept", acc0, 1);
    idle();
    chk("t1_mult_a", mult_a, 3);
    chk("t1_mult_b", mult_b, 5);
    tick(); tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_result", rsp_result_0, 15);
    chk("t1_rsp_src", rsp_src, 0);
    chk("t1_rsp_id", rsp_id, 7);
    repeat (4) tick();

    // Both requesters streaming in mode 01: grants alternate.
    nacc = 0; order = '0;
    set_req(0, 1, 2'b01, r81(), r81(), 1, 0, 4'h1);
    set_req(1, 1, 2'b01, r81(), r81(), 0, 1, 4'h9);
    for (int i = 0; i < 40 && nacc < 4; i++) begin
      tick();
      if (acc0) begin order[nacc] = 1'b0; nacc++; set_req(0, 1, 2'b01, r81(), r81(), 1, 0, 4'(nacc)); end
      if (acc1) begin order[nacc] = 1'b1; nacc++; set_req(1, 1, 2'b01, r81(), r81(), 0, 1, 4'(8 + nacc)); end
    end
    chk("t2_accepts", nacc, 4);
    chk("t2_order", order, 4'b1010);
    idle();
    repeat (10) tick();

    // Backpressure: FIFO_DEPTH accepts, then one more only after a pop.
    rsp_ready = 1'b0; nacc = 0;
    set_req(0, 1, 2'b01, r81(), r81(), 0, 0, 4'h3);
    repeat (10) begin
      tick();
      if (acc0) begin nacc++; set_req(0, 1, 2'b01, r81(), r81(), 0, 0, 4'(nacc)); end
    end
    chk("t3_accepts_full", nacc, 4);
    rsp_ready = 1'b1;
    nacc = 0;
    tick();
    if (acc0) nacc++;
    rsp_ready = 1'b0;
    repeat (6) begin
      tick();
      if (acc0) begin nacc++; set_req(0, 1, 2'b01, r81(), r81(), 0, 0, 4'hc); end
    end
    chk("t3_accepts_after_pop", nacc, 1);
    idle(); rsp_ready = 1'b1;
    repeat (12) tick();

    // Mode change with two mode-00 ops in flight.
    got = 0;
    set_req(0, 1, 2'b00, r81(), r81(), 1, 1, 4'h2);
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = acc0; end
    chk("t4_pre_accept", got, 1);
    idle();
    repeat (8) tick();
    set_req(0, 1, 2'b00, r81(), r81(), 1, 0, 4'h4);
    tick();
    chk("t4_acc_a", acc0, 1);
    set_req(0, 1, 2'b00, r81(), r81(), 0, 1, 4'h5);
    tick();
    chk("t4_acc_b", acc0, 1);
    set_req(0, 1, 2'b10, r81(), r81(), 0, 0, 4'h6);
    got = 0; w = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (acc0) got = 1; else w++;
    end
    chk("t4_switch_accept", got, 1);
    chk("t4_wait_cycles", w, 4);
    idle();
    repeat (8) tick();

    // Illegal mode between two mode-01 requests.
    rsp_log.delete();
    got = 0;
    set_req(0, 1, 2'b01, r81(), r81(), 0, 0, 4'ha);
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = acc0; end
    chk("t5_first_accept", got, 1);
    set_req(0, 1, 2'b11, r81(), r81(), 1, 1, 4'hb);
    tick();
    chk("t5_illegal_accept", acc0, 1);
    set_req(0, 1, 2'b01, r81(), r81(), 0, 0, 4'hc);
    tick();
    chk("t5_third_accept", acc0, 1);
    idle();
    repeat (10) tick();
    chk("t5_rsp_count", rsp_log.size(), 3);
    if (rsp_log.size() == 3) begin
      chk("t5_err_first", rsp_log[0].err, 0);
      chk("t5_err_middle", rsp_log[1].err, 1);
      chk("t5_zero_middle", rsp_log[1].r0, 0);
      chk("t5_id_order", {rsp_log[0].id, rsp_log[1].id, rsp_log[2].id}, 12'habc);
    end
    chk("t5_mode", mult_mode, 2'b01);

    // Reset with two ops in flight and one waiting in the FIFO.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1, 2'b01, r81(), r81(), 0, 0, 4'(k));
      tick();
      chk("t6_accept", acc0, 1);
    end
    idle();
    chk("t6_pre_valid", rsp_valid, 1);
    reset = 1'b0;
    model_clear();
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_mode", mult_mode, 0);
    chk("t6_rst_mult_a", mult_a, 0);
    repeat (3) tick();
    reset = 1'b1;
    rsp_ready = 1'b1;
    repeat (8) tick();
    set_req(0, 1, 2'b00, 81'd3, 81'd5, 0, 0, 4'h1);
    tick();
    chk("t6_post_accept", acc0, 1);
    idle();
    repeat (6) tick();

    // Random traffic with occasional mode changes, illegal modes and withdrawals.
    phase = 2'b01;
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0) phase = 2'($urandom_range(0, 2));
      for (int n = 0; n < 2; n++) begin
        got = (n == 0) ? req0_valid : req1_valid;
        if (!got && $urandom_range(0, 1) == 1) begin
          w = $urandom_range(0, 9);
          m = (w == 0) ? 2'b11 : ((w < 3) ? 2'($urandom_range(0, 2)) : phase);
          set_req(n, 1, m, r81(), r81(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom));
        end else if (got && $urandom_range(0, 49) == 0) begin
          if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    idle(); rsp_ready = 1'b1;
    repeat (20) tick();
    chk("end_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_mode_scheduler.md
Name: mac_mode_scheduler

Overview:
- Arbitrates two requesters onto one shared 27x27 / SIMD-9x9 / SIMD-4x4 multiplier.
- Owns the multiplier's mode input. Drains the multiplier pipeline before any mode change.
- Tags each operation, captures results into a small FIFO with backpressure, and returns them in issue order.
- Sits between the PE-level issue logic and the multiplier instance.

Parameters:
- LATENCY, 2: cycles from mult_* inputs valid to mult_result_* valid (fixed, no stall). Legal range 1..8.
- ID_W, 4: width of the requester transaction tag.
- FIFO_DEPTH, 4: result FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  request valid (N=0,1).
- reqN_ready  out  1  request accepted this cycle.
- reqN_mode  in  2  00=27x27, 01=sum 9x9, 10=sum 4x4, 11=illegal.
- reqN_a, reqN_b  in  81  operands.
- reqN_a_sign, reqN_b_sign  in  1  signedness.
- reqN_id  in  ID_W  tag.
- mult_a, mult_b  out  81  registered operands to the multiplier.
- mult_a_sign, mult_b_sign  out  1  registered signedness.
- mult_mode  out  2  current mode register.
- mult_result_0, mult_result_1  in  54  multiplier outputs.
- mult_simd_carry  in  12  multiplier SIMD carries.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer ready.
- rsp_result_0, rsp_result_1  out  54  results.
- rsp_simd_carry  out  12  carries.
- rsp_src  out  1  granted requester index.
- rsp_id  out  ID_W  echoed tag.
- rsp_err  out  1  set for illegal-mode requests.
- busy  out  1  high when inflight != 0, FIFO non-empty, or state != RUN.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, mode_reg=00, state=RUN, RR pointer=0, inflight=0, FIFO empty. Any in-flight operations are discarded. No response is emitted for an operation that was in flight when reset asserted.
- Arbitration:
  - Round-robin. If both requesters are valid, grant the one equal to the pointer.
  - After each accepted request the pointer becomes the other index.
  - If only one requester is valid, grant it and leave the pointer unchanged.
- Credit rule: issue allowed only if inflight + fifo_count < FIFO_DEPTH. A FIFO pop in the same cycle does not add credit until the next cycle.
- reqN_ready: combinational. It is 1 only for the granted requester, only in state RUN, only when credit is available, and only when the granted mode equals mode_reg or is 11.
- FSM:
  - RUN: a request whose mode (not 11) differs from mode_reg is not accepted. The FSM goes to DRAIN.
  - DRAIN: hold. When inflight==0, load mode_reg with the pending mode, then go to SWITCH. The pending mode is re-sampled from the current granted requester on each DRAIN cycle. If that requester drops valid, return to RUN without a mode change.
  - SWITCH: one bubble cycle so multiplier operand muxing settles. Then go to RUN.
- Issue: on an accepting edge, register the operands, signs and tag into mult_*. Push {valid, src, id, err} into a LATENCY-deep shift register; inflight increments.
- Capture: when the shift register's final stage is valid, write {mult_result_*, carry, src, id, err} into the FIFO; inflight decrements. The capture edge is LATENCY cycles after the issue edge.
- Simultaneous issue and capture in one cycle: inflight is unchanged.
- Illegal mode 11:
  - Accepted in RUN regardless of mode_reg, and never triggers DRAIN.
  - mult_* operands are driven to 0 for that slot.
  - The captured entry has err=1 and results forced to 0.
  - Order is preserved.
- FIFO:
  - rsp_* is driven from the head; pop on rsp_valid & rsp_ready.
  - Write pointer wraps modulo FIFO_DEPTH, as does the read pointer.
  - Overflow is impossible by the credit rule. Write into a full FIFO is an assertion failure.
- Responses return strictly in issue order across both requesters.
- mult_mode never changes while inflight != 0.

Test Plan:
- Single req0, mode 00, a=3, b=5, signs 0 → mult_* valid the cycle after accept. With the multiplier model returning 15, rsp_result_0=15, rsp_src=0, rsp_id echoed, LATENCY+1 cycles after accept.
- Both requesters valid continuously, same mode 01 → grants alternate 0,1,0,1. Responses come back in that order with matching ids.
- rsp_ready=0, FIFO_DEPTH=4, req0 streaming → exactly 4 accepts, then reqN_ready=0. After one pop, one further accept on the following cycle.
- Two ops in mode 00 in flight, then a req in mode 10 → no accept until inflight=0, then one SWITCH bubble. mult_mode changes to 10 only after the last mode-00 result is captured; the req is accepted on the next cycle.
- Request with mode 11 between two mode-01 requests → accepted without drain. Three responses in order; the middle one has rsp_err=1 and zero results; mult_mode stays 01.
- reset asserted with 2 ops in flight and 1 in the FIFO → all outputs 0 immediately. After release, no stale rsp_valid; new requests behave as after power-up.
